// File: rtl/npu_host_seq.sv
// -----------------------------------------------------------------------------
// npu_host_seq
//
// Bus-master sequencer for the NPU memory-mapped host port. Commands arrive on
// a valid/ready stream and are issued as single-cycle writes, single-cycle
// reads, or poll loops that re-read an address until (douta & mask) == mask or
// POLL_MAX reads have been made. Read data and poll results leave on a
// valid/ready response stream.
//
// Parameters:
//   RD_LAT   - cycles from the read-issue edge to the sampling of douta (1..4)
//   POLL_MAX - maximum reads per POLL before timeout (>= 1)
//   POLL_GAP - idle cycles between consecutive poll reads (>= 0)
//   CNT_W    - width of the poll and gap counters (must hold POLL_MAX)
//
// Ports:
//   clk, rst_ni            - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    - command handshake
//   cmd_op                 - 0=WRITE 1=READ 2=POLL 3=reserved (dropped)
//   cmd_addr, cmd_data     - bus address; write data (WRITE) or mask (POLL)
//   rsp_valid/rsp_ready    - response handshake
//   rsp_data, rsp_err      - captured douta; 1 = poll timeout
//   ena, wea, addra, dina  - host bus outputs
//   douta                  - host bus read data (registered inside the NPU)
//   busy                   - sequencer not idle
//
// Build option:
//   NPU_HOST_SEQ_WR_ACK_EN - when defined, every WRITE also returns a response
//                            (rsp_data=0, rsp_err=0) so the controller can
//                            order writes ahead of later reads. When undefined,
//                            writes are posted with no response.
// -----------------------------------------------------------------------------
module npu_host_seq #(
    parameter int RD_LAT   = 1,
    parameter int POLL_MAX = 1024,
    parameter int POLL_GAP = 2,
    parameter int CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        ena,
    output logic        wea,
    output logic [15:0] addra,
    output logic [31:0] dina,
    input  logic [31:0] douta,
    output logic        busy
);

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_POLL  = 2'd2;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = (POLL_GAP > 0) ? CNT_W'(POLL_GAP - 1) : '0;
    localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RD_WAIT,
        S_GAP,
        S_RSP
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             is_poll_q;
    logic [31:0]      mask_q;
    logic [CNT_W-1:0] tmr_q;
    logic [CNT_W-1:0] poll_cnt_q;

    logic accept;
    logic sample;
    logic match;
    logic poll_last;
    logic done_rd;

    assign accept    = cmd_valid && cmd_ready;
    // douta is valid on the last edge of RD_WAIT, RD_LAT edges after the RD cycle
    assign sample    = (state_q == S_RD_WAIT) && (tmr_q == WAIT_LAST);
    assign match     = (douta & mask_q) == mask_q;
    assign poll_last = poll_cnt_q == POLL_LAST;
    // A plain READ always finishes; a POLL finishes on a match or on its last read
    assign done_rd   = sample && (!is_poll_q || match || poll_last);

    // ---- state register ----
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_WRITE: state_d = S_WR;
                        OP_READ:  state_d = S_RD;
                        OP_POLL:  state_d = S_RD;
                        default:  state_d = S_IDLE;
                    endcase
                end
            end
            S_WR: begin
`ifdef NPU_HOST_SEQ_WR_ACK_EN
                state_d = S_RSP;
`else
                state_d = S_IDLE;
`endif
            end
            S_RD: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (done_rd) begin
                    state_d = S_RSP;
                end else if (sample) begin
                    state_d = (POLL_GAP == 0) ? S_RD : S_GAP;
                end
            end
            S_GAP: begin
                if (tmr_q == GAP_LAST) begin
                    state_d = S_RD;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---- outputs decoded from state ----
    // Bus strobes come straight from the state register so they drop in the
    // same cycle rst_ni falls.
    always_comb begin
        ena       = 1'b0;
        wea       = 1'b0;
        rsp_valid = 1'b0;
        cmd_ready = 1'b0;
        busy      = (state_q != S_IDLE);
        case (state_q)
            S_IDLE:  cmd_ready = rst_ni;
            S_WR: begin
                ena = 1'b1;
                wea = 1'b1;
            end
            S_RD:    ena       = 1'b1;
            S_RSP:   rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // ---- command latch, timers and response capture ----
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            addra      <= '0;
            dina       <= '0;
            mask_q     <= '0;
            is_poll_q  <= 1'b0;
            tmr_q      <= '0;
            poll_cnt_q <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            // One timer serves both RD_WAIT and GAP; it restarts on every state change
            if ((state_q == S_RD_WAIT || state_q == S_GAP) && (state_d == state_q)) begin
                tmr_q <= tmr_q + CNT_W'(1);
            end else begin
                tmr_q <= '0;
            end

            // Reserved ops leave the bus registers untouched
            if (accept && (cmd_op != 2'd3)) begin
                addra      <= cmd_addr;
                is_poll_q  <= (cmd_op == OP_POLL);
                poll_cnt_q <= '0;
                if (cmd_op == OP_WRITE) begin
                    dina <= cmd_data;
                end
                if (cmd_op == OP_POLL) begin
                    mask_q <= cmd_data;
                end
            end

            if (done_rd) begin
                rsp_data <= douta;
                rsp_err  <= is_poll_q && !match;
            end else if (sample) begin
                poll_cnt_q <= poll_cnt_q + CNT_W'(1);
            end

`ifdef NPU_HOST_SEQ_WR_ACK_EN
            if (state_q == S_WR) begin
                rsp_data <= '0;
                rsp_err  <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_npu_host_seq.sv
// -----------------------------------------------------------------------------
// tb_npu_host_seq
//
// Self-checking bench for npu_host_seq. A registered bus model stands in for
// the NPU host port; a reference model computes expected read data, poll
// outcomes, bus read counts and response latencies from the command rules.
// Directed steps cover the basic WRITE/READ/POLL cases, back-pressure and
// mid-operation reset, followed by a randomized command sequence.
// -----------------------------------------------------------------------------
module tb_npu_host_seq;

    localparam int RD_LAT   = 1;
    localparam int POLL_MAX = 8;
    localparam int POLL_GAP = 2;
    localparam int SPACING  = 1 + RD_LAT + POLL_GAP;

    logic        clk       = 1'b0;
    logic        rst_ni    = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op    = 2'd0;
    logic [15:0] cmd_addr  = 16'h0;
    logic [31:0] cmd_data  = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        ena;
    logic        wea;
    logic [15:0] addra;
    logic [31:0] dina;
    logic [31:0] douta     = 32'h0;
    logic        busy;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int acc_cyc = 0;

    npu_host_seq #(
        .RD_LAT  (RD_LAT),
        .POLL_MAX(POLL_MAX),
        .POLL_GAP(POLL_GAP),
        .CNT_W   (16)
    ) dut (
        .clk      (clk),
        .rst_ni   (rst_ni),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .ena      (ena),
        .wea      (wea),
        .addra    (addra),
        .dina     (dina),
        .douta    (douta),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- bus model (registered douta, like the NPU) ----------------
    logic [31:0] bus_mem [256];
    logic [31:0] ref_mem [256];
    logic        poll_mode = 1'b0;
    int          poll_n    = 0;
    int          poll_base = 0;
    int          hit_n     = 1;
    logic [31:0] hit_val   = 32'h0;
    logic [31:0] miss_base = 32'h0;
    logic [31:0] pmask     = 32'h0;

    // Value returned by the n-th read (1-based) of a poll scenario
    function automatic logic [31:0] poll_val(input int n);
        if (n >= hit_n) return hit_val | pmask;
        return (miss_base + 32'(n)) & ~pmask;
    endfunction

    always @(posedge clk) begin
        if (ena) begin
            if (wea) begin
                bus_mem[addra[7:0]] <= dina;
            end else if (poll_mode) begin
                poll_n = poll_n + 1;
                douta <= poll_val(poll_n - poll_base);
            end else begin
                douta <= bus_mem[addra[7:0]];
            end
        end
    end

    // ---------------- bus monitor ----------------
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic        prev_ena = 1'b0;
    logic [15:0] last_rd_addr = 16'h0;
    logic [15:0] last_wr_addr = 16'h0;
    logic [31:0] last_rd_dina = 32'h0;
    logic [31:0] last_wr_data = 32'h0;
    int          rd_cyc_q [$];

    always @(negedge clk) begin
        if (rst_ni) begin
            checks++;
            assert (!(ena && prev_ena)) else begin
                errors++;
                $error("FAIL ena_back_to_back observed=1 expected=0 cyc=%0d", cyc);
            end
            checks++;
            assert (!(wea && !ena)) else begin
                errors++;
                $error("FAIL wea_without_ena observed=1 expected=0 cyc=%0d", cyc);
            end
        end
        prev_ena = ena;
        if (ena && wea) begin
            wr_cnt++;
            last_wr_addr = addra;
            last_wr_data = dina;
        end
        if (ena && !wea) begin
            rd_cnt++;
            last_rd_addr = addra;
            last_rd_dina = dina;
            rd_cyc_q.push_back(cyc);
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [15:0] addr, input logic [31:0] data);
        int n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_addr  = 16'($urandom);
        cmd_data  = $urandom;
    endtask

    // Waits for the response, checks latency/data/err, holds rsp_ready low for
    // 'hold' cycles checking stability, then consumes it.
    task automatic await_rsp(input int exp_lat, input logic [31:0] exp_data, input logic exp_err,
                             input int hold, input string tag);
        int n = 0;
        tick();
        while (!rsp_valid && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_latency"}, 32'(cyc - acc_cyc + 1), 32'(exp_lat));
        chk({tag, "_rsp_data"}, rsp_data, exp_data);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "_hold_data"}, rsp_data, exp_data);
            chk({tag, "_hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
            chk({tag, "_hold_ena"}, 32'(ena), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        tick();
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_idle_cmd_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    // Reference poll outcome: first read whose value covers the mask, else timeout
    task automatic model_poll(input logic [31:0] mask, output int nreads,
                              output logic [31:0] data, output logic err);
        nreads = 0;
        data   = 32'h0;
        err    = 1'b1;
        for (int n = 1; n <= POLL_MAX; n++) begin
            data   = poll_val(n);
            nreads = n;
            if ((data & mask) == mask) begin
                err = 1'b0;
                break;
            end
        end
    endtask

    logic [31:0] exp_dina = 32'h0;

    task automatic run_write(input logic [15:0] addr, input logic [31:0] data);
        int w0 = wr_cnt;
        send(2'd0, addr, data);
        tick();
        chk("wr_ena", 32'(ena), 32'd1);
        chk("wr_wea", 32'(wea), 32'd1);
        chk("wr_addra", 32'(addra), 32'(addr));
        chk("wr_dina", dina, data);
        ref_mem[addr[7:0]] = data;
        exp_dina = data;
`ifdef NPU_HOST_SEQ_WR_ACK_EN
        await_rsp(2, 32'h0, 1'b0, 0, "wr_ack");
`else
        tick();
        chk("wr_next_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("wr_no_rsp", 32'(rsp_valid), 32'd0);
        chk("wr_next_ena", 32'(ena), 32'd0);
`endif
        chk("wr_count", 32'(wr_cnt), 32'(w0 + 1));
        chk("wr_last_data", last_wr_data, data);
    endtask

    task automatic run_read(input logic [15:0] addr, input int hold);
        int r0 = rd_cnt;
        poll_mode = 1'b0;
        rd_cyc_q.delete();
        send(2'd1, addr, $urandom);
        await_rsp(RD_LAT + 2, ref_mem[addr[7:0]], 1'b0, hold, "read");
        chk("read_bus_reads", 32'(rd_cnt), 32'(r0 + 1));
        chk("read_addra", 32'(last_rd_addr), 32'(addr));
        chk("read_dina_held", last_rd_dina, exp_dina);
        if (rd_cyc_q.size() > 0) chk("read_issue_cycle", 32'(rd_cyc_q[0]), 32'(acc_cyc));
    endtask

    task automatic run_poll(input logic [15:0] addr, input logic [31:0] mask, input int h,
                            input int hold);
        int          r0 = rd_cnt;
        int          nr;
        int          lat;
        logic [31:0] ed;
        logic        ee;
        pmask     = mask;
        hit_n     = h;
        hit_val   = $urandom;
        miss_base = $urandom;
        poll_base = poll_n;
        poll_mode = 1'b1;
        rd_cyc_q.delete();
        model_poll(mask, nr, ed, ee);
        lat = nr * (1 + RD_LAT) + (nr - 1) * POLL_GAP + 1;
        send(2'd2, addr, mask);
        await_rsp(lat, ed, ee, hold, "poll");
        chk("poll_bus_reads", 32'(rd_cnt), 32'(r0 + nr));
        chk("poll_addra", 32'(last_rd_addr), 32'(addr));
        if (rd_cyc_q.size() > 0) chk("poll_first_read", 32'(rd_cyc_q[0]), 32'(acc_cyc));
        for (int i = 1; i < rd_cyc_q.size(); i++) begin
            chk("poll_spacing", 32'(rd_cyc_q[i] - rd_cyc_q[i-1]), 32'(SPACING));
        end
        poll_mode = 1'b0;
    endtask

    task automatic run_rsvd(input logic [15:0] addr);
        int r0 = rd_cnt;
        int w0 = wr_cnt;
        send(2'd3, addr, $urandom);
        tick();
        chk("rsvd_ena", 32'(ena), 32'd0);
        chk("rsvd_busy", 32'(busy), 32'd0);
        chk("rsvd_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        chk("rsvd_no_rsp", 32'(rsp_valid), 32'd0);
        chk("rsvd_bus_idle", 32'(rd_cnt + wr_cnt), 32'(r0 + w0));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        for (int i = 0; i < 256; i++) begin
            bus_mem[i] = 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
            ref_mem[i] = bus_mem[i];
        end
        bus_mem[2] = 32'h0000_00FF;
        ref_mem[2] = 32'h0000_00FF;

        // Reset state
        tick();
        chk("rst_ena", 32'(ena), 32'd0);
        chk("rst_wea", 32'(wea), 32'd0);
        chk("rst_addra", 32'(addra), 32'd0);
        chk("rst_dina", dina, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        rst_ni = 1'b1;
        tick();
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Directed cases
        run_write(16'h0001, 32'h0003_0201);
        run_read(16'h0002, 0);
        run_poll(16'h0001, 32'h0000_0001, 5, 0);
        run_poll(16'h0001, 32'h0000_0001, 100, 0);
        run_poll(16'h0003, 32'h0000_0000, 100, 0);
        run_read(16'h0001, 10);
        run_rsvd(16'h0004);

        // Reset during the GAP of a POLL that never matches
        pmask     = 32'h1;
        hit_n     = 100;
        miss_base = 32'h1234_0000;
        poll_base = poll_n;
        poll_mode = 1'b1;
        send(2'd2, 16'h0001, 32'h1);
        tick();
        tick();
        tick();
        chk("gap_busy", 32'(busy), 32'd1);
        chk("gap_ena", 32'(ena), 32'd0);
        rst_ni = 1'b0;
        #1;
        chk("midrst_ena", 32'(ena), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("midrst_addra", 32'(addra), 32'd0);
        chk("midrst_dina", dina, 32'd0);
        tick();
        tick();
        rst_ni    = 1'b1;
        poll_mode = 1'b0;
        exp_dina  = 32'h0;
        run_read(16'h0002, 0);

        // Reset while a read strobe is on the bus
        send(2'd1, 16'h0005, 32'h0);
        tick();
        chk("rd_cycle_ena", 32'(ena), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("rdrst_ena", 32'(ena), 32'd0);
        chk("rdrst_busy", 32'(busy), 32'd0);
        tick();
        rst_ni   = 1'b1;
        exp_dina = 32'h0;
        tick();
        run_read(16'h0001, 0);

        // Randomized command mix
        for (int it = 0; it < 40; it++) begin
            logic [1:0]  op;
            logic [15:0] addr;
            logic [31:0] mask;
            int          hold;
            op   = 2'($urandom_range(0, 3));
            addr = 16'($urandom);
            hold = $urandom_range(0, 3);
            case (op)
                2'd0: run_write(addr, $urandom);
                2'd1: run_read(addr, hold);
                2'd2: begin
                    mask = ($urandom_range(0, 4) == 0) ? 32'h0 : (($urandom & 32'h0F0F) | 32'h100);
                    run_poll(addr, mask, $urandom_range(1, 10), hold);
                end
                default: run_rsvd(addr);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/npu_host_seq.md
Name: npu_host_seq

Overview:
Bus-master sequencer that drives the NPU memory-mapped host port (ena/wea/addra/dina/douta) from the controller side. It accepts commands over a valid/ready stream and issues them as single-cycle bus writes, single-cycle reads, or poll loops that wait on a status bit. Read data and poll results return on a valid/ready response stream. It sits between the system controller or testbench driver and the npu block, replacing hand-timed host bus toggling.

Parameters:
RD_LAT, 1, cycles from the read-issue edge to the sampling of douta (douta is registered in the NPU); legal range 1..4
POLL_MAX, 1024, maximum reads per POLL command before timeout; >=1
POLL_GAP, 2, idle cycles between consecutive poll reads; >=0
CNT_W, 16, width of the poll and gap counters; must hold POLL_MAX

Ports:
clk  in  1  clock
rst_ni  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_op  in  2  0=WRITE, 1=READ, 2=POLL, 3=reserved (dropped, no bus activity)
cmd_addr  in  16  bus address
cmd_data  in  32  write data (WRITE) or bit mask (POLL)
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_data  out  32  captured douta
rsp_err  out  1  1 = poll timeout
ena  out  1  bus enable
wea  out  1  bus write enable
addra  out  16  bus address
dina  out  32  bus write data
douta  in  32  bus read data
busy  out  1  state != IDLE

Behaviour:
- Single clock, asynchronous active-low reset rst_ni; all registers clear immediately on rst_ni low.
- Reset values: ena=0, wea=0, addra=0, dina=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0. cmd_ready=0 while rst_ni is low, otherwise cmd_ready = (state==IDLE).
- States: IDLE, WR, RD, RD_WAIT, GAP, RSP.
- IDLE: on handshake, latch op/addr/data. WRITE->WR, READ->RD, POLL->RD with poll flag set and poll count=0, reserved->IDLE.
- WR: ena=1, wea=1, addra=addr, dina=data for exactly one cycle, then IDLE. No response is produced unless the optional feature is enabled.
- RD: ena=1, wea=0, addra=addr for exactly one cycle, then RD_WAIT. dina holds its last value.
- RD_WAIT: ena=0; douta is sampled RD_LAT cycles after the RD cycle.
  - READ: capture to rsp_data, err=0, go to RSP.
  - POLL, (douta & mask)==mask: capture, err=0, go to RSP.
  - POLL, no match and this was read number POLL_MAX: capture the last douta, err=1, go to RSP.
  - POLL, otherwise: increment count, go to GAP (or directly to RD if POLL_GAP=0).
- GAP: hold POLL_GAP cycles with ena=0, then RD.
- RSP: rsp_valid=1 with rsp_data and rsp_err held stable until rsp_ready; on the handshake go to IDLE. rsp_ready is ignored in other states.
- Mask of 0 on POLL: matches on the first read and takes one bus read.
- Throughput: WRITE = 1 bus cycle + 1 IDLE cycle. READ latency from accept to rsp_valid = 1 + 1 + RD_LAT cycles (rsp_valid first high in cycle RD_LAT+2 after the accept edge).
- ena is never high in two consecutive cycles. wea is only high together with ena.
- Reset mid-operation: any in-flight command or response is discarded. The bus returns to idle in the same cycle rst_ni falls.

Optional Feature:
Macro NPU_HOST_SEQ_WR_ACK_EN.
- Defined: WR goes to RSP instead of IDLE, with rsp_data=0 and rsp_err=0. Every command except reserved yields exactly one response, which lets the controller order writes before reads.
- Undefined: writes are posted with no response. The RSP path is reached only by READ and POLL.

Test Plan:
- WRITE addr 0x0001 data 0x00030201 -> cycle after accept: ena=1, wea=1, addra=0x0001, dina=0x00030201 for one cycle; cmd_ready high again the following cycle; no rsp (macro off).
- READ addr 0x0002, bus model returns 0x000000FF with RD_LAT=1 -> rsp_valid in the 3rd cycle after accept, rsp_data=0x000000FF, rsp_err=0.
- POLL addr 0x0001 mask 0x1, model sets bit0 on the 5th read, POLL_GAP=2 -> exactly 5 bus reads spaced 2+RD_LAT+1 cycles apart; rsp_data bit0=1, rsp_err=0.
- POLL with POLL_MAX=8, bit never set -> exactly 8 reads, then rsp_err=1 and rsp_data = the last douta.
- Hold rsp_ready low for 10 cycles after a READ -> rsp_valid and rsp_data stable, cmd_ready=0, no bus activity; one-cycle rsp_ready -> IDLE.
- Pull rst_ni low during the GAP of a POLL -> same-cycle ena=0, busy=0, rsp_valid=0; after release, a new READ completes normally.
